// File: rtl/weight_loader.sv
// North-edge weight transmitter for one systolic-array column: streams N weights down
// the column tagged with descending row indices, then waits out propagation and signals load_done.
module weight_loader #(
    parameter  int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter  int DATA_WIDTH_IN        = 8,
    localparam int IDX_W                = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     flush,
    input  logic                     w_valid,
    input  logic [DATA_WIDTH_IN-1:0] w_data,
    output logic                     w_ready,
    output logic [DATA_WIDTH_IN-1:0] col_weight_out,
    output logic [IDX_W-1:0]         col_index_out,
    output logic                     col_accept_w_out,
    output logic                     busy,
    output logic                     load_done
);

    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYSTOLIC_ARRAY_WIDTH - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(SYSTOLIC_ARRAY_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                beat_cnt, drain_cnt;
    logic                            beat;
    logic signed [DATA_WIDTH_IN-1:0] weight_p0;
    logic [IDX_W-1:0]                index_p0;
    logic                            vld_p0;

    // flush overrides every transition and also blocks the handshake in its own cycle
    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && beat_cnt == LAST_CNT) state_nxt = DRAIN;
            end
            DRAIN:   if (drain_cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            w_ready   = 1'b0;
        end
    end

    assign beat      = w_valid && w_ready;
    assign busy      = (state != IDLE);
    assign load_done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DRAIN spans N cycles so a beat stalled early still reaches the farthest row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else if (flush) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            beat_cnt  <= (state == LOAD)  ? beat_cnt + CNT_W'(beat) : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1        : '0;
        end
    end

    // Stage p0: registered column drive; weight/index hold between accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            weight_p0 <= '0;
            index_p0  <= '0;
        end else begin
            vld_p0 <= beat;
            if (beat) begin
                weight_p0 <= $signed(w_data);
                index_p0  <= TOP_IDX - beat_cnt[IDX_W-1:0];
            end
        end
    end

    assign col_weight_out   = weight_p0;
    assign col_index_out    = index_p0;
    assign col_accept_w_out = vld_p0;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized directed bench for weight_loader (N=4) with a behavioural 4-row pe column
// model used for the end-to-end load/switch scenario.
module tb_weight_loader;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          w_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_ready;
    logic [DW-1:0] col_weight_out;
    logic [IW-1:0] col_index_out;
    logic          col_accept_w_out;
    logic          busy;
    logic          load_done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_w = '0;
    logic [IW-1:0] exp_i = '0;
    logic          use_fixed = 1'b0;
    logic [DW-1:0] fixed_w [N];

    weight_loader #(.SYSTOLIC_ARRAY_WIDTH(N), .DATA_WIDTH_IN(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .col_weight_out(col_weight_out), .col_index_out(col_index_out),
        .col_accept_w_out(col_accept_w_out), .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    // Behavioural pe column: a row captures a weight whose tag matches it and stops its accept
    logic [DW-1:0] pe_w [N];
    logic [IW-1:0] pe_i [N];
    logic          pe_a [N];
    logic [DW-1:0] inact [N];
    logic [DW-1:0] act [N];
    logic [DW-1:0] in_w [N];
    logic [IW-1:0] in_i [N];
    logic          in_a [N];
    logic          sw = 1'b0;
    logic          south_clr = 1'b1;
    logic          south_seen;

    always_comb begin
        in_w[0] = col_weight_out;
        in_i[0] = col_index_out;
        in_a[0] = col_accept_w_out;
        for (int r = 1; r < N; r++) begin
            in_w[r] = pe_w[r-1];
            in_i[r] = pe_i[r-1];
            in_a[r] = pe_a[r-1];
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            pe_w[r] <= in_w[r];
            pe_i[r] <= in_i[r];
            if (south_clr) pe_a[r] <= 1'b0;
            else if (in_a[r] && in_i[r] == IW'(r)) begin
                inact[r] <= in_w[r];
                pe_a[r]  <= 1'b0;
            end else pe_a[r] <= in_a[r];
            if (sw) act[r] <= inact[r];
        end
        if (south_clr)         south_seen <= 1'b0;
        else if (pe_a[N-1])    south_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full load; gap_pct = chance (percent) of an idle valid cycle, poke = random start pulses
    task automatic run_load(input int gap_pct, input bit poke);
        int            cnt;
        int            guard;
        logic          v;
        logic [DW-1:0] d;
        start = 1'b1; w_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_in_load", w_ready, 1);
        chk("accept_before_beat", col_accept_w_out, 0);
        cnt = 0; guard = 0;
        while (cnt < N && guard < 200) begin
            v = ($urandom_range(99) >= gap_pct);
            d = use_fixed ? fixed_w[cnt] : DW'($urandom);
            w_valid = v; w_data = d;
            start = poke ? 1'($urandom_range(1)) : 1'b0;
            tick();
            guard++;
            if (v) begin
                exp_w = d;
                exp_i = IW'(N - 1 - cnt);
                cnt++;
            end
            chk("load_accept", col_accept_w_out, v);
            chk("load_weight", col_weight_out, exp_w);
            chk("load_index", col_index_out, exp_i);
            chk("load_no_done", load_done, 0);
            chk("load_busy", busy, 1);
            chk("load_ready", w_ready, (cnt < N));
        end
        chk("load_beats_in_budget", cnt, N);
        for (int k = 1; k <= N; k++) begin
            w_valid = 1'($urandom_range(1)); w_data = DW'($urandom);
            start = poke ? 1'($urandom_range(1)) : 1'b0;
            tick();
            chk("drain_accept", col_accept_w_out, 0);
            chk("drain_weight_hold", col_weight_out, exp_w);
            chk("drain_index_hold", col_index_out, exp_i);
            chk("drain_load_done", load_done, (k == N));
            chk("drain_busy", busy, 1);
            chk("drain_ready", w_ready, 0);
        end
        start = 1'b0; w_valid = 1'b0;
        tick();
        chk("post_done_pulse", load_done, 0);
        chk("post_idle_busy", busy, 0);
        chk("post_idle_ready", w_ready, 0);
    endtask

    initial begin
        #1;
        chk("rst_weight", col_weight_out, 0);
        chk("rst_index", col_index_out, 0);
        chk("rst_accept", col_accept_w_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_ready", w_ready, 0);
        tick(); tick();
        rst = 1'b0; south_clr = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // back-to-back with the documented weights
        fixed_w[0] = 8'd11; fixed_w[1] = 8'd22; fixed_w[2] = 8'd33; fixed_w[3] = 8'd44;
        use_fixed = 1'b1;
        run_load(0, 1'b0);
        use_fixed = 1'b0;

        // random valid gaps
        run_load(40, 1'b0);
        run_load(60, 1'b0);

        // start pulses while busy
        run_load(30, 1'b1);

        // flush after two beats with a third offered in the same cycle
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            w_valid = 1'b1; w_data = DW'($urandom);
            exp_w = w_data; exp_i = IW'(N - 1 - b);
            tick();
            chk("pre_flush_index", col_index_out, exp_i);
        end
        w_valid = 1'b1; w_data = DW'($urandom); flush = 1'b1;
        #1;
        chk("flush_blocks_ready", w_ready, 0);
        tick();
        flush = 1'b0; w_valid = 1'b0;
        chk("flush_accept", col_accept_w_out, 0);
        chk("flush_busy", busy, 0);
        chk("flush_weight_hold", col_weight_out, exp_w);
        chk("flush_index_hold", col_index_out, exp_i);
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("flush_no_done", load_done, 0);
        end
        run_load(0, 1'b0);

        // asynchronous reset mid-drain
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < N; b++) begin
            w_valid = 1'b1; w_data = DW'($urandom | 1);
            tick();
        end
        w_valid = 1'b0;
        tick(); tick();
        chk("drain_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_weight", col_weight_out, 0);
        chk("arst_index", col_index_out, 0);
        chk("arst_accept", col_accept_w_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", load_done, 0);
        tick();
        rst = 1'b0;
        exp_w = '0; exp_i = '0;
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("arst_no_done", load_done, 0);
        end
        run_load(20, 1'b0);

        // column integration: load, switch, read back the active registers
        south_clr = 1'b1; tick(); south_clr = 1'b0;
        fixed_w[0] = 8'hFB; fixed_w[1] = 8'h07; fixed_w[2] = 8'h80; fixed_w[3] = 8'h7F;
        use_fixed = 1'b1;
        run_load(0, 1'b0);
        use_fixed = 1'b0;
        sw = 1'b1; tick(); sw = 1'b0;
        chk("col_row3", act[3], 8'hFB);
        chk("col_row2", act[2], 8'h07);
        chk("col_row1", act[1], 8'h80);
        chk("col_row0", act[0], 8'h7F);
        chk("col_south_quiet", south_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
